// File: rtl/mcu_pkg.sv
// Shared constants for the MCU interrupt controller: config addresses, GIE bit, FSM encoding.
package mcu_pkg;

  localparam logic [1:0] CFG_CTRL = 2'd0;
  localparam logic [1:0] CFG_MASK = 2'd1;
  localparam logic [1:0] CFG_PEND = 2'd2;
  localparam logic [1:0] CFG_EDGE = 2'd3;

  localparam int GIE_BIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } int_state_t;

  // ROM entry address; wraps modulo 256 like the core's 8-bit ROM pointer.
  function automatic logic [7:0] vec_addr(input logic [7:0] base, input logic [7:0] stride,
                                          input logic [7:0] idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/mcu_irq_sync.sv
// Two-flop synchroniser for one raw interrupt line plus a rising-edge detector on the synced level.
module mcu_irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic irq_raw,
  output logic level,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq_raw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/mcu_int_ctrl.sv
// Prioritised vectored interrupt controller for the 16-bit MCU core.
// Optional macro INT_NESTING_EN allows higher-priority sources to pre-empt an in-service one.
//
// state | meaning
// IDLE  | nothing requested, nothing in service
// REQ   | int_req high, int_vec tracks current winner until int_ack
// SVC   | at least one source in service, waiting for int_ret
module mcu_int_ctrl
  import mcu_pkg::*;
#(
  parameter int          NUM_SRC    = 4,
  parameter logic [7:0]  VEC_BASE   = 8'd19,
  parameter logic [7:0]  VEC_STRIDE = 8'd15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_we,
  input  logic               cfg_re,
  input  logic [1:0]         cfg_addr,
  input  logic [15:0]        cfg_wdata,
  output logic [15:0]        cfg_rdata,
  output logic               int_req,
  output logic [7:0]         int_vec,
  input  logic               int_ack,
  input  logic               int_ret,
  output logic [NUM_SRC-1:0] in_service
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] lvl, rise;
  logic               gie;
  logic [NUM_SRC-1:0] mask, edge_en, pend_q, pend, elig, cand;
  logic [NUM_SRC-1:0] above, ret_hot, w1c, ack_clr, pend_nxt;
  logic [IW-1:0]      win, win_q;
  logic               any;
  int_state_t         state;
  logic               unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    mcu_irq_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .irq_raw (irq_src[g]),
      .level   (lvl[g]),
      .rise    (rise[g])
    );
  end

  assign pend = (pend_q & edge_en) | (lvl & ~edge_en);
  assign elig = gie ? (pend & mask) : '0;

  // above: sources strictly higher priority than every in-service one; ret_hot: top in-service bit
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    above   = '0;
    ret_hot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      above[i]   = ~(blocked | in_service[i]);
      ret_hot[i] = in_service[i] & ~blocked;
      blocked    = blocked | in_service[i];
    end
  end

`ifdef INT_NESTING_EN
  assign cand = elig & above;
`else
  assign cand = (|in_service) ? '0 : elig;
`endif

  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) win = IW'(i);
    end
  end
  assign any = |cand;

  assign ack_clr  = (state == ST_REQ && int_ack) ? (NUM_SRC'(1) << win_q) : '0;
  assign w1c      = (cfg_we && cfg_addr == CFG_PEND) ? cfg_wdata[NUM_SRC-1:0] : '0;
  // a new edge beats a same-cycle clear from either W1C or ack
  assign pend_nxt = (rise & edge_en) | (pend_q & edge_en & ~w1c & ~ack_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gie       <= 1'b0;
      mask      <= '0;
      edge_en   <= '0;
      pend_q    <= '0;
      cfg_rdata <= '0;
    end else begin
      pend_q <= pend_nxt;
      if (cfg_we) begin
        case (cfg_addr)
          CFG_CTRL: gie     <= cfg_wdata[GIE_BIT];
          CFG_MASK: mask    <= cfg_wdata[NUM_SRC-1:0];
          CFG_EDGE: edge_en <= cfg_wdata[NUM_SRC-1:0];
          default:  ;
        endcase
      end
      if (cfg_re) begin
        case (cfg_addr)
          CFG_CTRL: cfg_rdata <= 16'(gie) << GIE_BIT;
          CFG_MASK: cfg_rdata <= 16'(mask);
          CFG_PEND: cfg_rdata <= 16'(pend);
          default:  cfg_rdata <= 16'(edge_en);
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      int_req    <= 1'b0;
      int_vec    <= '0;
      win_q      <= '0;
      in_service <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            state   <= ST_REQ;
            int_req <= 1'b1;
            win_q   <= win;
            int_vec <= vec_addr(VEC_BASE, VEC_STRIDE, 8'(win));
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            in_service <= in_service | ack_clr;
            int_req    <= 1'b0;
            state      <= ST_SVC;
          end else if (!any) begin
            int_req <= 1'b0;
            state   <= (|in_service) ? ST_SVC : ST_IDLE;
          end else begin
            win_q   <= win;
            int_vec <= vec_addr(VEC_BASE, VEC_STRIDE, 8'(win));
          end
        end
        ST_SVC: begin
          if (int_ret) begin
            in_service <= in_service & ~ret_hot;
            if ((in_service & ~ret_hot) == '0) state <= ST_IDLE;
          end else if (any) begin
            state   <= ST_REQ;
            int_req <= 1'b1;
            win_q   <= win;
            int_vec <= vec_addr(VEC_BASE, VEC_STRIDE, 8'(win));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_int_ctrl.sv
// Scoreboard bench for mcu_int_ctrl: expected vectors and register reads are queued at stimulus time.
module tb_mcu_int_ctrl;

  localparam logic [1:0] A_CTRL = 2'd0, A_MASK = 2'd1, A_PEND = 2'd2, A_EDGE = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  irq_src = '0;
  logic        cfg_we = 1'b0, cfg_re = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic [15:0] cfg_rdata;
  logic        int_req;
  logic [7:0]  int_vec;
  logic        int_ack = 1'b0, int_ret = 1'b0;
  logic [3:0]  in_service;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  vec_q[$];
  logic [15:0] rd_q[$];

  mcu_int_ctrl dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .cfg_we(cfg_we), .cfg_re(cfg_re),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .int_req(int_req), .int_vec(int_vec), .int_ack(int_ack), .int_ret(int_ret),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_vec(input int i);
    return 8'(19 + i * 15);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [15:0] d);
    cfg_re = 1'b1; cfg_addr = a;
    tick();
    cfg_re = 1'b0;
    d = cfg_rdata;
  endtask

  task automatic pulse_src(input logic [3:0] s);
    irq_src = s;
    tick();
    irq_src = '0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic pulse_ret();
    int_ret = 1'b1; tick(); int_ret = 1'b0;
  endtask

  task automatic wait_req(input int max, output bit seen);
    int n;
    n = 0; seen = 1'b0;
    while (!seen && n < max) begin
      tick();
      n++;
      if (int_req === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [15:0] d, e;
    n_cmp++;
    if ({int_req, int_vec, in_service, cfg_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got req=%0b vec=%0d isv=%0h rdata=%0h, want all 0",
               int_req, int_vec, in_service, cfg_rdata);
    end
    rd_q.push_back(16'h0000);
    cfg_read(A_PEND, d); e = rd_q.pop_front();
    n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL reset_pend: got %0h want %0h", d, e); end
  endtask

  task automatic test_stray();
    pulse_ack();
    pulse_ret();
    n_cmp++;
    if (int_req !== 1'b0 || in_service !== 4'h0) begin
      n_err++;
      $display("FAIL stray_pulses: got req=%0b isv=%0h want 0/0", int_req, in_service);
    end
  endtask

  task automatic test_basic();
    logic [15:0] d, e;
    logic [7:0]  v;
    cfg_write(A_CTRL, 16'h8000);
    cfg_write(A_MASK, 16'h0003);
    cfg_write(A_EDGE, 16'h0003);
    vec_q.push_back(exp_vec(1));
    pulse_src(4'b0010);
    tick(); tick();
    n_cmp++;
    if (int_req !== 1'b0) begin n_err++; $display("FAIL req_early: got %0b want 0", int_req); end
    tick();
    v = vec_q.pop_front();
    n_cmp++;
    if (int_req !== 1'b1 || int_vec !== v) begin
      n_err++;
      $display("FAIL req_latency_vec: got req=%0b vec=%0d want 1/%0d", int_req, int_vec, v);
    end
    pulse_ack();
    n_cmp++;
    if (int_req !== 1'b0 || in_service !== 4'h2) begin
      n_err++;
      $display("FAIL ack_basic: got req=%0b isv=%0h want 0/2", int_req, in_service);
    end
    rd_q.push_back(16'h0000);
    cfg_read(A_PEND, d); e = rd_q.pop_front();
    n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL pend_after_ack: got %0h want %0h", d, e); end
    pulse_ret();
    n_cmp++;
    if (in_service !== 4'h0) begin n_err++; $display("FAIL ret_basic: got %0h want 0", in_service); end
  endtask

  task automatic test_priority();
    logic [7:0] v;
    bit seen;
    vec_q.push_back(exp_vec(0));
    vec_q.push_back(exp_vec(1));
    pulse_src(4'b0011);
    wait_req(8, seen);
    v = vec_q.pop_front();
    n_cmp++;
    if (!seen || int_vec !== v) begin
      n_err++; $display("FAIL prio_first: got seen=%0b vec=%0d want 1/%0d", seen, int_vec, v);
    end
    pulse_ack();
    n_cmp++;
    if (in_service !== 4'h1) begin n_err++; $display("FAIL prio_isv: got %0h want 1", in_service); end
    pulse_ret();
    n_cmp++;
    if (int_req !== 1'b0 || in_service !== 4'h0) begin
      n_err++; $display("FAIL prio_ret: got req=%0b isv=%0h want 0/0", int_req, in_service);
    end
    tick();
    v = vec_q.pop_front();
    n_cmp++;
    if (int_req !== 1'b1 || int_vec !== v) begin
      n_err++; $display("FAIL prio_second: got req=%0b vec=%0d want 1/%0d", int_req, int_vec, v);
    end
    pulse_ack();
    pulse_ret();
  endtask

  task automatic test_mask_drop();
    logic [15:0] d, e;
    logic [7:0]  v;
    bit seen;
    vec_q.push_back(exp_vec(0));
    pulse_src(4'b0001);
    wait_req(8, seen);
    v = vec_q.pop_front();
    n_cmp++;
    if (!seen || int_vec !== v) begin
      n_err++; $display("FAIL mask_req: got seen=%0b vec=%0d want 1/%0d", seen, int_vec, v);
    end
    cfg_write(A_MASK, 16'h0000);
    tick();
    n_cmp++;
    if (int_req !== 1'b0) begin n_err++; $display("FAIL mask_drop: got %0b want 0", int_req); end
    rd_q.push_back(16'h0001);
    cfg_read(A_PEND, d); e = rd_q.pop_front();
    n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL mask_pend_kept: got %0h want %0h", d, e); end
    vec_q.push_back(exp_vec(0));
    cfg_write(A_MASK, 16'h0003);
    wait_req(4, seen);
    v = vec_q.pop_front();
    n_cmp++;
    if (!seen || int_vec !== v) begin
      n_err++; $display("FAIL mask_return: got seen=%0b vec=%0d want 1/%0d", seen, int_vec, v);
    end
    pulse_ack();
    pulse_ret();
  endtask

  task automatic test_w1c();
    logic [15:0] d, e;
    cfg_write(A_EDGE, 16'h0007);
    pulse_src(4'b0100);
    tick(); tick();
    rd_q.push_back(16'h0004);
    cfg_read(A_PEND, d); e = rd_q.pop_front();
    n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL edge_pend_set: got %0h want %0h", d, e); end
    irq_src = 4'b0100; tick(); irq_src = '0; tick();
    cfg_write(A_PEND, 16'h0004);
    rd_q.push_back(16'h0004);
    cfg_read(A_PEND, d); e = rd_q.pop_front();
    n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL set_beats_w1c: got %0h want %0h", d, e); end
    cfg_write(A_PEND, 16'h0004);
    rd_q.push_back(16'h0000);
    cfg_read(A_PEND, d); e = rd_q.pop_front();
    n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL w1c_clear: got %0h want %0h", d, e); end
    irq_src = 4'b1000; tick(); tick();
    cfg_write(A_PEND, 16'h0008);
    rd_q.push_back(16'h0008);
    cfg_read(A_PEND, d); e = rd_q.pop_front();
    n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL level_w1c_ignored: got %0h want %0h", d, e); end
    irq_src = '0; tick(); tick();
    rd_q.push_back(16'h0000);
    cfg_read(A_PEND, d); e = rd_q.pop_front();
    n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL level_follow: got %0h want %0h", d, e); end
  endtask

  task automatic test_nesting();
    logic [7:0] v;
    bit seen;
    vec_q.push_back(exp_vec(1));
    pulse_src(4'b0010);
    wait_req(8, seen);
    v = vec_q.pop_front();
    n_cmp++;
    if (!seen || int_vec !== v) begin
      n_err++; $display("FAIL nest_outer: got seen=%0b vec=%0d want 1/%0d", seen, int_vec, v);
    end
    pulse_ack();
    pulse_src(4'b0001);
`ifdef INT_NESTING_EN
    vec_q.push_back(exp_vec(0));
    wait_req(8, seen);
    v = vec_q.pop_front();
    n_cmp++;
    if (!seen || int_vec !== v) begin
      n_err++; $display("FAIL nest_inner: got seen=%0b vec=%0d want 1/%0d", seen, int_vec, v);
    end
    pulse_ack();
    n_cmp++;
    if (in_service !== 4'h3) begin n_err++; $display("FAIL nest_isv: got %0h want 3", in_service); end
    pulse_ret();
    n_cmp++;
    if (in_service !== 4'h2) begin n_err++; $display("FAIL nest_unwind: got %0h want 2", in_service); end
    pulse_ret();
`else
    begin
      int hi;
      hi = 0;
      repeat (6) begin tick(); if (int_req !== 1'b0) hi++; end
      n_cmp++;
      if (hi != 0) begin n_err++; $display("FAIL no_nest_suppress: got %0d req cycles want 0", hi); end
    end
    vec_q.push_back(exp_vec(0));
    pulse_ret();
    wait_req(4, seen);
    v = vec_q.pop_front();
    n_cmp++;
    if (!seen || int_vec !== v) begin
      n_err++; $display("FAIL no_nest_after_ret: got seen=%0b vec=%0d want 1/%0d", seen, int_vec, v);
    end
    pulse_ack();
    pulse_ret();
`endif
    n_cmp++;
    if (in_service !== 4'h0) begin n_err++; $display("FAIL nest_done: got %0h want 0", in_service); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d, e;
    logic [7:0]  v;
    bit seen;
    int hi;
    vec_q.push_back(exp_vec(1));
    pulse_src(4'b0010);
    wait_req(8, seen);
    v = vec_q.pop_front();
    n_cmp++;
    if (!seen || int_vec !== v) begin
      n_err++; $display("FAIL rst_setup: got seen=%0b vec=%0d want 1/%0d", seen, int_vec, v);
    end
    pulse_ack();
    pulse_src(4'b0100);
    tick(); tick();
    rd_q.push_back(16'h0004);
    cfg_read(A_PEND, d); e = rd_q.pop_front();
    n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL rst_pend_before: got %0h want %0h", d, e); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({int_req, int_vec, in_service, cfg_rdata} !== '0) begin
      n_err++;
      $display("FAIL rst_async: got req=%0b vec=%0d isv=%0h rdata=%0h, want all 0",
               int_req, int_vec, in_service, cfg_rdata);
    end
    tick();
    rst = 1'b0;
    rd_q.push_back(16'h0000);
    cfg_read(A_PEND, d); e = rd_q.pop_front();
    n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL rst_pend_after: got %0h want %0h", d, e); end
    rd_q.push_back(16'h0000);
    cfg_read(A_CTRL, d); e = rd_q.pop_front();
    n_cmp++;
    if (d !== e) begin n_err++; $display("FAIL rst_ctrl_after: got %0h want %0h", d, e); end
    pulse_src(4'b0010);
    hi = 0;
    repeat (6) begin tick(); if (int_req !== 1'b0) hi++; end
    n_cmp++;
    if (hi != 0) begin n_err++; $display("FAIL rst_no_req: got %0d req cycles want 0", hi); end
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_stray();
    test_basic();
    test_priority();
    test_mask_drop();
    test_w1c();
    test_nesting();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
